// File: rtl/reg_file_dump.sv
// reg_file_dump: walks register addresses 0..N-1 through the read port and streams each word on VALID/READY.
// Optional trailing XOR checksum beat when RF_DUMP_CHECKSUM_EN is defined.
module reg_file_dump #(
   parameter int unsigned N      = 8,
   parameter int unsigned W      = 8,
   parameter int unsigned A      = 3,
   parameter int unsigned RD_LAT = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   output logic [A-1:0] o_rf_addr,
   input  logic [W-1:0] i_rf_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [A-1:0] o_addr,
   output logic         o_last,
   output logic         o_csum,
   output logic         o_busy,
   output logic         o_done
);

   localparam int unsigned  CW        = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
   localparam logic [A-1:0] LAST_ADDR = A'(N - 1);
   localparam logic [CW-1:0] LAT      = CW'(RD_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [A-1:0]  r_rf_addr, w_rf_addr;
   logic          r_valid, w_valid;
   logic [W-1:0]  r_data, w_data;
   logic [A-1:0]  r_addr, w_addr;
   logic          r_last, w_last;
   logic          r_busy, r_done;
   logic          w_xfer;

`ifdef RF_DUMP_CHECKSUM_EN
   logic [W-1:0]  r_acc, w_acc;
   logic          r_csum_phase, w_csum_phase;
   logic          r_csum, w_csum;
`endif

   assign w_xfer = r_valid && i_ready;

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_rf_addr = r_rf_addr;
      w_valid   = r_valid;
      w_data    = r_data;
      w_addr    = r_addr;
      w_last    = r_last;
`ifdef RF_DUMP_CHECKSUM_EN
      w_acc        = r_acc;
      w_csum_phase = r_csum_phase;
      w_csum       = r_csum;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state   = S_WAIT;
               w_rf_addr = '0;
               w_cnt     = LAT;
`ifdef RF_DUMP_CHECKSUM_EN
               w_acc        = '0;
               w_csum_phase = 1'b0;
`endif
            end
         end
         S_WAIT: begin
            w_cnt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               w_valid = 1'b1;
               w_state = S_PRESENT;
`ifdef RF_DUMP_CHECKSUM_EN
               if (r_csum_phase) begin
                  w_data = r_acc;
                  w_addr = '0;
                  w_last = 1'b1;
                  w_csum = 1'b1;
               end else begin
                  w_data = i_rf_data;
                  w_addr = r_rf_addr;
                  w_last = 1'b0;
                  w_csum = 1'b0;
               end
`else
               w_data = i_rf_data;
               w_addr = r_rf_addr;
               w_last = (r_rf_addr == LAST_ADDR);
`endif
            end
         end
         S_PRESENT: begin
            if (w_xfer) begin
               w_valid = 1'b0;
               w_last  = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
               w_csum = 1'b0;
               if (r_csum_phase) begin
                  w_state = S_DONE;
               end else begin
                  // address holds at N-1 while the checksum beat is fetched
                  w_acc   = r_acc ^ r_data;
                  w_cnt   = LAT;
                  w_state = S_WAIT;
                  if (r_rf_addr == LAST_ADDR) begin
                     w_csum_phase = 1'b1;
                  end else begin
                     w_rf_addr = r_rf_addr + 1'b1;
                  end
               end
`else
               if (r_rf_addr == LAST_ADDR) begin
                  w_state = S_DONE;
               end else begin
                  w_rf_addr = r_rf_addr + 1'b1;
                  w_cnt     = LAT;
                  w_state   = S_WAIT;
               end
`endif
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rf_addr <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_addr    <= '0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
         r_acc        <= '0;
         r_csum_phase <= 1'b0;
         r_csum       <= 1'b0;
`endif
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_rf_addr <= w_rf_addr;
         r_valid   <= w_valid;
         r_data    <= w_data;
         r_addr    <= w_addr;
         r_last    <= w_last;
         r_busy    <= (w_state != S_IDLE);
         r_done    <= (w_state == S_DONE);
`ifdef RF_DUMP_CHECKSUM_EN
         r_acc        <= w_acc;
         r_csum_phase <= w_csum_phase;
         r_csum       <= w_csum;
`endif
      end
   end

   assign o_rf_addr = r_rf_addr;
   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_addr    = r_addr;
   assign o_last    = r_last;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
`ifdef RF_DUMP_CHECKSUM_EN
   assign o_csum    = r_csum;
`else
   assign o_csum    = 1'b0;
`endif

endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Sequential reader for the parameterized register file: on a single START pulse it walks every register address from 0 to N-1 and reads each word through the file's read port. Each word is streamed out on a valid/ready handshake tagged with its address. It sits between the register file's OUT1 read port and the debug/trace path, and lets the host snapshot architectural state without stalling the write port.

## Interface
- N, 8: number of registers scanned; 1 ≤ N ≤ 2^A.
- W, 8: register width in bits.
- A, 3: register address width in bits.
- RD_LAT, 1: cycles between driving RF_ADDR and sampling RF_DATA; ≥ 1.

Ports (clock and reset first):
- CLK  input  1  single clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  begin a dump; sampled only in IDLE.
- RF_ADDR  output  A  read address driven to the register file's read port.
- RF_DATA  input  W  read data returned by the register file.
- VALID  output  1  DATA_OUT/ADDR_OUT/LAST/CSUM hold a beat.
- READY  input  1  consumer accepts the beat.
- DATA_OUT  output  W  register contents, or checksum on the checksum beat.
- ADDR_OUT  output  A  address of the current beat.
- LAST  output  1  final beat of the dump.
- CSUM  output  1  current beat is the checksum beat; constant 0 when the checksum option is compiled out.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse after the final beat transfers.

## Operation
- FSM states:
  - IDLE: entered from reset and after DONE. START=1 → WAIT; RF_ADDR←0; wait counter←RD_LAT; checksum accumulator←0.
  - WAIT: counter decrements each edge. At the edge where the counter is 1: DATA_OUT←RF_DATA, ADDR_OUT←RF_ADDR, VALID←1 → PRESENT.
  - PRESENT: the outputs hold stable while READY=0. A beat transfers on an edge with VALID&&READY.
    - Non-final beat: VALID←0; RF_ADDR←RF_ADDR+1; counter←RD_LAT → WAIT.
    - Final beat: VALID←0 → DONE.
  - DONE: DONE=1 for exactly one cycle → IDLE.
- The final register beat is RF_ADDR == N-1. The address counter never wraps past N-1. With N = 2^A the increment after N-1 is never taken.
- LAST=1 together with VALID on the final beat only.
- START while BUSY=1 is ignored; START held high through DONE does not retrigger until the IDLE cycle.
- The dump is read-only. Register writes during a dump are allowed, and each beat reflects the register value at its sample edge.
- Asserting RESET at any point aborts the dump immediately, with no DONE pulse. The consumer must discard a partial dump.

## Timing
- Reset values: RF_ADDR=0, DATA_OUT=0, ADDR_OUT=0, VALID=0, LAST=0, CSUM=0, BUSY=0, DONE=0, state=IDLE.
- START sampled at edge k → BUSY=1 after edge k. First VALID rises after edge k+RD_LAT.
- With READY held at 1, each beat costs RD_LAT+1 cycles.
- The dump of N registers finishes its last transfer at edge k+N·(RD_LAT+1). DONE is high for the following cycle. The checksum beat, when enabled, adds RD_LAT+1 cycles before DONE.
- All outputs are registered; there is no combinational path from READY or START to any output.

## Configuration
- RF_DUMP_CHECKSUM_EN defined:
  - Each transferred register word is XORed into a W-bit accumulator.
  - After beat N-1 transfers, the block runs one more WAIT of RD_LAT cycles, then presents an extra beat with DATA_OUT=accumulator, ADDR_OUT=0, CSUM=1, LAST=1.
  - Register beat N-1 then has LAST=0. DONE follows the checksum beat.
- RF_DUMP_CHECKSUM_EN undefined: there is no accumulator and no extra beat. CSUM is tied to 0, and LAST marks register beat N-1.

## Test plan
- Reset then idle, START=0 for 20 cycles → all outputs 0; RF_ADDR stays 0.
- Registers preloaded with 0x01,0x04,0x07,0x0A,0x0D,0x10,0x13,0x16; RD_LAT=1, READY=1, START at edge 0:
  - 8 beats at edges 2,4,…,16, with ADDR_OUT 0..7 and matching data.
  - LAST on beat 7; DONE during the cycle after edge 16.
- Same preload with RF_DUMP_CHECKSUM_EN defined → 9th beat with DATA_OUT=0x10, CSUM=1, LAST=1; beat 7 has LAST=0.
- READY toggling 0,0,1 per beat → DATA_OUT/ADDR_OUT/VALID held stable while READY=0; 8 words delivered in order with none lost or duplicated.
- START pulsed again mid-dump at beat 3 → ignored; a single DONE; exactly 8 beats.
- RESET asserted asynchronously while VALID=1 on beat 4 → all outputs 0 immediately and no DONE. A later START produces a full dump starting at address 0.
